// File: rtl/npu_sequencer_pkg.sv
// Op codes and FSM state encoding shared by the NPU sequencer and its move buffer.
// Latency: n/a (definitions only).  Backpressure: n/a.
package pkg_npu_op;

    localparam logic [3:0] OP_OS   = 4'b1111;
    localparam logic [3:0] OP_MOVE = 4'b0001;
    localparam logic [3:0] OP_NONE = 4'b0111;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        WB,
        MOVE,
        DONE
    } state_t;

endpackage

// File: rtl/npu_sequencer_move_buffer.sv
// Single-entry valid/ready output register for OMEM move words; grants read issue.
// Latency: word valid 1 cycle after its read.  Backpressure: issue blocked while full and !ready.
module npu_move_buffer (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_remain,
    input  logic i_ready,
    output logic o_ren,
    output logic o_valid
);

    logic r_valid;

    // A read may replace the held word only when that word leaves this cycle.
    assign o_ren   = i_remain & (~r_valid | i_ready);
    assign o_valid = r_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= o_ren | (r_valid & ~i_ready);
        end
    end

endmodule

// File: rtl/npu_sequencer.sv
// Command sequencer: runs output-stationary compute phases or an OMEM move stream.
// Latency: compute done at T+K+3N+1, zero-length done at T+1.  Backpressure: move stalls on !move_ready_i.
module npu_sequencer
    import pkg_npu_op::*;
#(
    parameter int DWidth     = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int ARRAY_DIM  = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         op_valid_i,
    input  logic [3:0]                   op_type_i,
    input  logic [DWidth-1:0]            op_arg_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o,
    output logic                         in_ren_o,
    output logic [$clog2(MEM_DEPTH)-1:0] in_raddr_o,
    output logic                         pe_clr_o,
    output logic                         pe_en_o,
    output logic                         pe_drain_o,
    output logic                         out_wen_o,
    output logic [$clog2(MEM_DEPTH)-1:0] out_waddr_o,
    output logic                         move_ren_o,
    output logic [$clog2(MEM_DEPTH)-1:0] move_raddr_o,
    output logic                         move_valid_o,
    input  logic                         move_ready_i
);

    // The bus address width only matters to the decoder in front of this block.
    localparam int IDX_W = (ADDR_WIDTH > 0) ? $clog2(MEM_DEPTH) : 1;

    state_t             r_state, w_state_nxt;
    logic [DWidth-1:0]  r_arg;
    logic [IDX_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_hs;
    logic               r_ren_d;
    logic               r_err;
    logic               w_cmd;
    logic               w_cnt_inc;
    logic               w_remain;
    logic               w_hs;

    assign w_cmd = op_valid_i && (op_type_i == OP_OS || op_type_i == OP_MOVE);
    assign w_hs  = move_valid_o & move_ready_i;

    npu_move_buffer u_move_buf (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_remain (w_remain),
        .i_ready  (move_ready_i),
        .o_ren    (move_ren_o),
        .o_valid  (move_valid_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = 1'b0;
        w_remain    = 1'b0;
        in_ren_o    = 1'b0;
        pe_clr_o    = 1'b0;
        pe_drain_o  = 1'b0;
        out_wen_o   = 1'b0;
        case (r_state)
            IDLE: begin
                if (op_valid_i && op_type_i == OP_OS) begin
                    w_state_nxt = (op_arg_i == '0) ? DONE : CLEAR;
                end else if (op_valid_i && op_type_i == OP_MOVE) begin
                    w_state_nxt = (op_arg_i == '0) ? DONE : MOVE;
                end
            end
            CLEAR: begin
                pe_clr_o    = 1'b1;
                w_state_nxt = FEED;
            end
            FEED: begin
                in_ren_o  = 1'b1;
                w_cnt_inc = 1'b1;
                if (DWidth'(r_cnt) == r_arg - DWidth'(1)) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                w_cnt_inc = 1'b1;
                if (r_cnt == IDX_W'(2 * ARRAY_DIM - 2)) w_state_nxt = WB;
            end
            WB: begin
                out_wen_o  = 1'b1;
                pe_drain_o = 1'b1;
                w_cnt_inc  = 1'b1;
                if (r_cnt == IDX_W'(ARRAY_DIM - 1)) w_state_nxt = DONE;
            end
            MOVE: begin
                w_remain  = (DWidth'(r_cnt) != r_arg);
                w_cnt_inc = move_ren_o;
                if (w_hs && DWidth'(r_hs) == r_arg - DWidth'(1)) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Counter restarts on every phase change so each phase indexes from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_arg   <= '0;
            r_cnt   <= '0;
            r_hs    <= '0;
            r_ren_d <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ren_d <= in_ren_o;
            r_err   <= w_cmd && (r_state != IDLE);
            if (r_state == IDLE && w_cmd) r_arg <= op_arg_i;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (w_cnt_inc)         r_cnt <= r_cnt + IDX_W'(1);
            if (r_state != MOVE) r_hs <= '0;
            else if (w_hs)       r_hs <= r_hs + IDX_W'(1);
        end
    end

    assign busy_o       = (r_state != IDLE);
    assign done_o       = (r_state == DONE);
    assign err_o        = r_err;
    assign pe_en_o      = r_ren_d | (r_state == FLUSH);
    assign in_raddr_o   = in_ren_o   ? r_cnt : '0;
    assign out_waddr_o  = out_wen_o  ? r_cnt : '0;
    assign move_raddr_o = move_ren_o ? r_cnt : '0;

endmodule

// File: tb/tb_npu_sequencer.sv
// Scoreboard bench for npu_sequencer: per-strobe expected events queued at issue, popped by a monitor.
module tb_npu_sequencer;
    import pkg_npu_op::*;

    localparam int N    = 4;
    localparam int K_CLR = 0, K_RD = 1, K_PE = 2, K_WR = 3, K_DN = 4, K_ER = 5, K_MR = 6, K_HS = 7;
    localparam int NK   = 8;

    typedef struct packed { int cyc; int addr; } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [3:0] op_type = 4'd0;
    logic [7:0] op_arg = 8'd0;
    logic       move_ready = 1'b0;
    logic       busy, done, err, in_ren, pe_clr, pe_en, pe_drain, out_wen, move_ren, move_valid;
    logic [7:0] in_raddr, out_waddr, move_raddr;

    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    int last_hs_cyc = -1;
    int last_done_cyc = -1;
    ev_t q_exp [NK][$];
    int  pend [$];
    string kname [NK] = '{"pe_clr", "in_ren", "pe_en", "out_wen", "done", "err", "move_ren", "move_hs"};

    npu_sequencer #(.DWidth(8), .ADDR_WIDTH(32), .ARRAY_DIM(N), .MEM_DEPTH(256)) dut (
        .clk_i(clk), .rst_ni(rst_n), .op_valid_i(op_valid), .op_type_i(op_type), .op_arg_i(op_arg),
        .busy_o(busy), .done_o(done), .err_o(err), .in_ren_o(in_ren), .in_raddr_o(in_raddr),
        .pe_clr_o(pe_clr), .pe_en_o(pe_en), .pe_drain_o(pe_drain), .out_wen_o(out_wen),
        .out_waddr_o(out_waddr), .move_ren_o(move_ren), .move_raddr_o(move_raddr),
        .move_valid_o(move_valid), .move_ready_i(move_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic s [NK];
        int   a [NK];
        ev_t  e;
        for (int k = 0; k < NK; k++) begin s[k] = 1'b0; a[k] = 0; end
        s[K_CLR] = pe_clr;
        s[K_RD]  = in_ren;   a[K_RD] = int'(in_raddr);
        s[K_PE]  = pe_en;
        s[K_WR]  = out_wen;  a[K_WR] = int'(out_waddr);
        s[K_DN]  = done;
        s[K_ER]  = err;
        s[K_HS]  = move_valid && move_ready;
        if (s[K_HS]) begin
            a[K_HS] = (pend.size() > 0) ? pend.pop_front() : -1;
            last_hs_cyc = cyc;
        end
        s[K_MR] = move_ren;  a[K_MR] = int'(move_raddr);
        if (move_ren) pend.push_back(int'(move_raddr));
        if (done) last_done_cyc = cyc;
        for (int k = 0; k < NK; k++) begin
            if (s[k]) begin
                vectors++;
                if (q_exp[k].size() == 0) begin
                    miscompares++;
                    $display("FAIL %s: unexpected strobe at cycle %0d addr %0d, required none", kname[k], cyc, a[k]);
                end else begin
                    e = q_exp[k].pop_front();
                    if ((e.cyc >= 0 && e.cyc != cyc) || e.addr != a[k]) begin
                        miscompares++;
                        $display("FAIL %s: got cycle %0d addr %0d, required cycle %0d addr %0d",
                                 kname[k], cyc, a[k], e.cyc, e.addr);
                    end
                end
            end
        end
    end

    function automatic int pending_total();
        int t = 0;
        for (int k = 0; k < NK; k++) t += q_exp[k].size();
        return t;
    endfunction

    task automatic send(input int at, input logic [3:0] t, input logic [7:0] a, output int tc);
        do begin @(posedge clk); #1; end while (cyc < at);
        op_valid = 1'b1; op_type = t; op_arg = a; tc = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0; op_type = 4'd0; op_arg = 8'd0;
    endtask

    task automatic push_os(input int tc, input int k);
        if (k == 0) begin
            q_exp[K_DN].push_back('{cyc: tc + 1, addr: 0});
            return;
        end
        for (int off = 1; off <= k + 3 * N + 1; off++) begin
            if (off == 1) q_exp[K_CLR].push_back('{cyc: tc + off, addr: 0});
            if (off >= 2 && off <= k + 1) q_exp[K_RD].push_back('{cyc: tc + off, addr: off - 2});
            if (off >= 3 && off <= k + 2 * N) q_exp[K_PE].push_back('{cyc: tc + off, addr: 0});
            if (off >= k + 2 * N + 1 && off <= k + 3 * N)
                q_exp[K_WR].push_back('{cyc: tc + off, addr: off - (k + 2 * N + 1)});
            if (off == k + 3 * N + 1) q_exp[K_DN].push_back('{cyc: tc + off, addr: 0});
        end
    endtask

    task automatic test_reset();
        logic [40:0] all_out;
        rst_n = 1'b0;
        #1;
        all_out = {busy, done, err, in_ren, pe_clr, pe_en, pe_drain, out_wen, move_ren, move_valid,
                   in_raddr, out_waddr, move_raddr, 7'd0};
        vectors++;
        if (all_out !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", all_out);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_os_k3();
        int tc;
        send(0, OP_OS, 8'd3, tc);
        push_os(tc, 3);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL os_k3_busy_start: got %b, required 1", busy);
        end
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (pending_total() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL os_k3_complete: %0d events missing, busy %b, required 0 and 0", pending_total(), busy);
        end
    endtask

    task automatic test_os_k0();
        int tc;
        send(0, OP_OS, 8'd0, tc);
        push_os(tc, 0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL os_k0_busy: got %b, required 1", busy);
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (pending_total() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL os_k0_complete: %0d events missing, busy %b, required 0 and 0", pending_total(), busy);
        end
    endtask

    task automatic test_ignored_op();
        int tc;
        send(0, OP_NONE, 8'd5, tc);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ignored_op_busy: got %b, required 0", busy);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_move();
        int tc;
        move_ready = 1'b1;
        send(0, OP_MOVE, 8'd5, tc);
        for (int i = 0; i < 5; i++) begin
            q_exp[K_MR].push_back('{cyc: -1, addr: i});
            q_exp[K_HS].push_back('{cyc: -1, addr: i});
        end
        q_exp[K_DN].push_back('{cyc: -1, addr: 0});
        repeat (30) begin
            move_ready = ~move_ready;
            @(posedge clk); #1;
        end
        move_ready = 1'b0;
        vectors++;
        if (pending_total() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL move_complete: %0d events missing, busy %b, required 0 and 0", pending_total(), busy);
        end
        vectors++;
        if (last_done_cyc !== last_hs_cyc + 1) begin
            miscompares++;
            $display("FAIL move_done_timing: got done cycle %0d, required %0d", last_done_cyc, last_hs_cyc + 1);
        end
        vectors++;
        if (move_valid !== 1'b0 || pend.size() !== 0) begin
            miscompares++;
            $display("FAIL move_drained: valid %b, %0d words held, required 0 and 0", move_valid, pend.size());
        end
    endtask

    task automatic test_err_while_busy();
        int tc, tc2;
        send(0, OP_OS, 8'd3, tc);
        push_os(tc, 3);
        send(tc + 5, OP_MOVE, 8'd2, tc2);
        q_exp[K_ER].push_back('{cyc: tc2 + 1, addr: 0});
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (pending_total() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL err_os_complete: %0d events missing, busy %b, required 0 and 0", pending_total(), busy);
        end
    endtask

    task automatic test_back_to_back();
        int tc, tc2, tc3;
        send(0, OP_OS, 8'd1, tc);
        push_os(tc, 1);
        send(tc + 1 + 3 * N + 2, OP_OS, 8'd2, tc2);
        push_os(tc2, 2);
        send(tc2 + 2 + 3 * N + 2, OP_MOVE, 8'd0, tc3);
        q_exp[K_DN].push_back('{cyc: tc3 + 1, addr: 0});
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (pending_total() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back: %0d events missing, busy %b, required 0 and 0", pending_total(), busy);
        end
    endtask

    task automatic test_reset_mid_feed();
        int tc;
        logic [40:0] all_out;
        send(0, OP_OS, 8'd8, tc);
        push_os(tc, 8);
        while (cyc < tc + 5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        for (int k = 0; k < NK; k++) q_exp[k].delete();
        pend.delete();
        #1;
        all_out = {busy, done, err, in_ren, pe_clr, pe_en, pe_drain, out_wen, move_ren, move_valid,
                   in_raddr, out_waddr, move_raddr, 7'd0};
        vectors++;
        if (all_out !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got %h, required 0", all_out);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, OP_OS, 8'd2, tc);
        push_os(tc, 2);
        repeat (20) @(posedge clk);
        #1;
        vectors++;
        if (pending_total() !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_rerun: %0d events missing, busy %b, required 0 and 0", pending_total(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_os_k3();
        test_os_k0();
        test_ignored_op();
        test_move();
        test_err_while_busy();
        test_back_to_back();
        test_reset_mid_feed();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
